// File: rtl/cu_pkg.sv
// Shared types for the hardwired control unit: sequencer states, opcode
// values, instruction classes and the bundled control word.
package cu_pkg;

    localparam int OPW = 5;
    localparam logic [OPW-1:0] ADD_OP = 5'b00011;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_IN   = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALTED
    } state_t;

    typedef enum logic [3:0] {
        CL_LD, CL_LDI, CL_ST, CL_ALU_R, CL_ALU_I, CL_MULDIV, CL_NEGNOT, CL_BR,
        CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_UNDEF
    } cls_t;

    typedef struct packed {
        logic IRin;
        logic PCin;
        logic RYin;
        logic RZin;
        logic MARin;
        logic MDRin;
        logic HIin;
        logic LOin;
        logic Outport_in;
        logic HIout;
        logic LOout;
        logic Zhi_out;
        logic Zlo_out;
        logic PCout;
        logic MDRout;
        logic Inport_out;
        logic Cout;
        logic Mem_read;
        logic Mem_write;
        logic Gra;
        logic Grb;
        logic Grc;
        logic Rin;
        logic Rout;
        logic BAout;
        logic IncPC;
        logic [OPW-1:0] opcode;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Datapath-facing bundle of the control unit: IR/condition/stop inputs and
// every control strobe it drives.
interface control_unit_if;
    logic [31:0] IR;
    logic        con_ff_bit;
    logic        stop;
    logic        run;
    logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic Mem_read, Mem_write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic IncPC;
    logic [4:0] opcode;

    modport master (
        input  IR, con_ff_bit, stop,
        output run, IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in,
        output HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
        output Mem_read, Mem_write, Gra, Grb, Grc, Rin, Rout, BAout, IncPC, opcode
    );

    modport slave (
        output IR, con_ff_bit, stop,
        input  run, IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in,
        input  HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
        input  Mem_read, Mem_write, Gra, Grb, Grc, Rin, Rout, BAout, IncPC, opcode
    );
endinterface

// File: rtl/cu_class_decode.sv
// Maps the IR opcode field onto the execute-sequence class; unused opcodes
// fall into CL_UNDEF and are treated like nop.
module cu_class_decode
    import cu_pkg::*;
(
    input  logic [OPW-1:0] i_op,
    output cls_t           o_class
);

    always_comb begin
        o_class = CL_UNDEF;
        case (i_op)
            OP_LD:   o_class = CL_LD;
            OP_LDI:  o_class = CL_LDI;
            OP_ST:   o_class = CL_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     o_class = CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:
                     o_class = CL_ALU_I;
            OP_MUL, OP_DIV: o_class = CL_MULDIV;
            OP_NEG, OP_NOT: o_class = CL_NEGNOT;
            OP_BR:   o_class = CL_BR;
            OP_JR:   o_class = CL_JR;
            OP_IN:   o_class = CL_IN;
            OP_OUT:  o_class = CL_OUT;
            OP_MFHI: o_class = CL_MFHI;
            OP_MFLO: o_class = CL_MFLO;
            OP_NOP:  o_class = CL_NOP;
            OP_HALT: o_class = CL_HALT;
            default: o_class = CL_UNDEF;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch in T0-T2, class-specific execute in T3-T7,
// branch-condition capture, halt instruction and deferred stop request.
module control_unit
    import cu_pkg::*;
(
    input logic clock,
    input logic clear,
    control_unit_if.master bus
);

    state_t         r_state;
    state_t         w_nextState;
    logic           r_taken;
    logic           r_stopPend;
    logic           w_last;
    cls_t           w_class;
    logic [OPW-1:0] w_op;
    ctrl_t          w_ctrl;

    assign w_op = bus.IR[31:27];

    cu_class_decode u_decode (
        .i_op    (w_op),
        .o_class (w_class)
    );

    // w_last marks the final step of a class; a pending stop redirects it to HALTED.
    always_comb begin
        w_nextState = r_state;
        w_last      = 1'b0;
        case (r_state)
            T0: w_nextState = T1;
            T1: w_nextState = T2;
            T2: begin
                if (w_class inside {CL_NOP, CL_UNDEF}) w_last = 1'b1;
                else                                  w_nextState = T3;
            end
            T3: begin
                if (w_class == CL_HALT) w_nextState = HALTED;
                else if (w_class inside {CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO}) w_last = 1'b1;
                else w_nextState = T4;
            end
            T4: begin
                if (w_class == CL_NEGNOT) w_last = 1'b1;
                else                      w_nextState = T5;
            end
            T5: begin
                if (w_class inside {CL_ALU_R, CL_ALU_I, CL_LDI}) w_last = 1'b1;
                else                                             w_nextState = T6;
            end
            T6: begin
                if (w_class inside {CL_BR, CL_MULDIV}) w_last = 1'b1;
                else                                   w_nextState = T7;
            end
            T7:      w_last = 1'b1;
            HALTED:  w_nextState = HALTED;
            default: w_nextState = T0;
        endcase
        if (w_last) w_nextState = r_stopPend ? HALTED : T0;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= T0;
            r_taken    <= 1'b0;
            r_stopPend <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (bus.stop) r_stopPend <= 1'b1;
            if (w_nextState == T0)
                r_taken <= 1'b0;
            else if (r_state == T3 && w_class == CL_BR)
                r_taken <= bus.con_ff_bit;
        end
    end

    always_comb begin
        w_ctrl        = '0;
        w_ctrl.opcode = ADD_OP;
        case (r_state)
            T0: begin
                w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1; w_ctrl.IncPC = 1'b1; w_ctrl.RZin = 1'b1;
            end
            T1: begin
                w_ctrl.Zlo_out = 1'b1; w_ctrl.PCin = 1'b1; w_ctrl.Mem_read = 1'b1; w_ctrl.MDRin = 1'b1;
            end
            T2: begin
                w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1;
            end
            T3: begin
                case (w_class)
                    CL_ALU_R, CL_ALU_I: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RYin = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RYin = 1'b1;
                    end
                    CL_MULDIV: begin
                        w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RYin = 1'b1;
                    end
                    CL_NEGNOT: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.opcode = w_op; w_ctrl.RZin = 1'b1;
                    end
                    CL_BR:   begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; end
                    CL_JR:   begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1; end
                    CL_IN:   begin w_ctrl.Inport_out = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    CL_OUT:  begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Outport_in = 1'b1; end
                    CL_MFHI: begin w_ctrl.HIout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    CL_MFLO: begin w_ctrl.LOout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (w_class)
                    CL_ALU_R: begin
                        w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.opcode = w_op; w_ctrl.RZin = 1'b1;
                    end
                    CL_ALU_I: begin
                        w_ctrl.Cout = 1'b1; w_ctrl.opcode = w_op; w_ctrl.RZin = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        w_ctrl.Cout = 1'b1; w_ctrl.RZin = 1'b1;
                    end
                    CL_MULDIV: begin
                        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.opcode = w_op; w_ctrl.RZin = 1'b1;
                    end
                    CL_NEGNOT: begin w_ctrl.Zlo_out = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    CL_BR:     begin w_ctrl.PCout = 1'b1; w_ctrl.RYin = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (w_class)
                    CL_ALU_R, CL_ALU_I, CL_LDI: begin
                        w_ctrl.Zlo_out = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                    end
                    CL_LD, CL_ST: begin w_ctrl.Zlo_out = 1'b1; w_ctrl.MARin = 1'b1; end
                    CL_MULDIV:    begin w_ctrl.Zlo_out = 1'b1; w_ctrl.LOin = 1'b1; end
                    CL_BR:        begin w_ctrl.Cout = 1'b1; w_ctrl.RZin = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                case (w_class)
                    CL_LD:     begin w_ctrl.Mem_read = 1'b1; w_ctrl.MDRin = 1'b1; end
                    CL_ST:     begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.MDRin = 1'b1; end
                    CL_MULDIV: begin w_ctrl.Zhi_out = 1'b1; w_ctrl.HIin = 1'b1; end
                    CL_BR: begin
                        w_ctrl.Zlo_out = r_taken; w_ctrl.PCin = r_taken;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (w_class)
                    CL_LD:   begin w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    CL_ST:   w_ctrl.Mem_write = 1'b1;
                    default: ;
                endcase
            end
            default: w_ctrl = '0;
        endcase
        if (clear) w_ctrl = '0;
    end

    assign bus.run        = !clear && (r_state != HALTED);
    assign bus.IRin       = w_ctrl.IRin;
    assign bus.PCin       = w_ctrl.PCin;
    assign bus.RYin       = w_ctrl.RYin;
    assign bus.RZin       = w_ctrl.RZin;
    assign bus.MARin      = w_ctrl.MARin;
    assign bus.MDRin      = w_ctrl.MDRin;
    assign bus.HIin       = w_ctrl.HIin;
    assign bus.LOin       = w_ctrl.LOin;
    assign bus.Outport_in = w_ctrl.Outport_in;
    assign bus.HIout      = w_ctrl.HIout;
    assign bus.LOout      = w_ctrl.LOout;
    assign bus.Zhi_out    = w_ctrl.Zhi_out;
    assign bus.Zlo_out    = w_ctrl.Zlo_out;
    assign bus.PCout      = w_ctrl.PCout;
    assign bus.MDRout     = w_ctrl.MDRout;
    assign bus.Inport_out = w_ctrl.Inport_out;
    assign bus.Cout       = w_ctrl.Cout;
    assign bus.Mem_read   = w_ctrl.Mem_read;
    assign bus.Mem_write  = w_ctrl.Mem_write;
    assign bus.Gra        = w_ctrl.Gra;
    assign bus.Grb        = w_ctrl.Grb;
    assign bus.Grc        = w_ctrl.Grc;
    assign bus.Rin        = w_ctrl.Rin;
    assign bus.Rout       = w_ctrl.Rout;
    assign bus.BAout      = w_ctrl.BAout;
    assign bus.IncPC      = w_ctrl.IncPC;
    assign bus.opcode     = w_ctrl.opcode;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected control words are
// queued when an instruction is launched and compared as the DUT steps.
module tb_control_unit;
    import cu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] word;
    } sbItem_t;

    logic clock;
    logic clear;
    int   checks;
    int   failures;
    sbItem_t sb[$];

    control_unit_if bus ();

    control_unit dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic ctrl_t observe();
        ctrl_t c;
        c.IRin = bus.IRin;       c.PCin = bus.PCin;       c.RYin = bus.RYin;
        c.RZin = bus.RZin;       c.MARin = bus.MARin;     c.MDRin = bus.MDRin;
        c.HIin = bus.HIin;       c.LOin = bus.LOin;       c.Outport_in = bus.Outport_in;
        c.HIout = bus.HIout;     c.LOout = bus.LOout;     c.Zhi_out = bus.Zhi_out;
        c.Zlo_out = bus.Zlo_out; c.PCout = bus.PCout;     c.MDRout = bus.MDRout;
        c.Inport_out = bus.Inport_out; c.Cout = bus.Cout; c.Mem_read = bus.Mem_read;
        c.Mem_write = bus.Mem_write;   c.Gra = bus.Gra;   c.Grb = bus.Grb;
        c.Grc = bus.Grc;         c.Rin = bus.Rin;         c.Rout = bus.Rout;
        c.BAout = bus.BAout;     c.IncPC = bus.IncPC;     c.opcode = bus.opcode;
        return c;
    endfunction

    function automatic int instrLen(input logic [4:0] op);
        if (op inside {OP_LD, OP_ST})                          return 8;
        if (op inside {OP_BR, OP_MUL, OP_DIV})                 return 7;
        if (op inside {[OP_ADD:OP_ORI], OP_LDI})               return 6;
        if (op inside {OP_NEG, OP_NOT})                        return 5;
        if (op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_HALT}) return 4;
        return 3;
    endfunction

    // Expected control word for execute step t of opcode op (tk = captured branch condition).
    function automatic ctrl_t stepWord(input logic [4:0] op, input int t, input logic tk);
        ctrl_t c;
        c = '0;
        c.opcode = ADD_OP;
        case (t)
            0: begin c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.RZin = 1; end
            1: begin c.Zlo_out = 1; c.PCin = 1; c.Mem_read = 1; c.MDRin = 1; end
            2: begin c.MDRout = 1; c.IRin = 1; end
            default: begin
                if (op inside {[OP_ADD:OP_ROL]}) begin
                    if (t == 3) begin c.Grb = 1; c.Rout = 1; c.RYin = 1; end
                    if (t == 4) begin c.Grc = 1; c.Rout = 1; c.opcode = op; c.RZin = 1; end
                    if (t == 5) begin c.Zlo_out = 1; c.Gra = 1; c.Rin = 1; end
                end else if (op inside {[OP_ADDI:OP_ORI]}) begin
                    if (t == 3) begin c.Grb = 1; c.Rout = 1; c.RYin = 1; end
                    if (t == 4) begin c.Cout = 1; c.opcode = op; c.RZin = 1; end
                    if (t == 5) begin c.Zlo_out = 1; c.Gra = 1; c.Rin = 1; end
                end else if (op inside {OP_LDI, OP_LD, OP_ST}) begin
                    if (t == 3) begin c.Grb = 1; c.BAout = 1; c.Rout = 1; c.RYin = 1; end
                    if (t == 4) begin c.Cout = 1; c.RZin = 1; end
                    if (t == 5 && op == OP_LDI) begin c.Zlo_out = 1; c.Gra = 1; c.Rin = 1; end
                    if (t == 5 && op != OP_LDI) begin c.Zlo_out = 1; c.MARin = 1; end
                    if (t == 6 && op == OP_LD) begin c.Mem_read = 1; c.MDRin = 1; end
                    if (t == 6 && op == OP_ST) begin c.Gra = 1; c.Rout = 1; c.MDRin = 1; end
                    if (t == 7 && op == OP_LD) begin c.MDRout = 1; c.Gra = 1; c.Rin = 1; end
                    if (t == 7 && op == OP_ST) c.Mem_write = 1;
                end else if (op inside {OP_MUL, OP_DIV}) begin
                    if (t == 3) begin c.Gra = 1; c.Rout = 1; c.RYin = 1; end
                    if (t == 4) begin c.Grb = 1; c.Rout = 1; c.opcode = op; c.RZin = 1; end
                    if (t == 5) begin c.Zlo_out = 1; c.LOin = 1; end
                    if (t == 6) begin c.Zhi_out = 1; c.HIin = 1; end
                end else if (op inside {OP_NEG, OP_NOT}) begin
                    if (t == 3) begin c.Grb = 1; c.Rout = 1; c.opcode = op; c.RZin = 1; end
                    if (t == 4) begin c.Zlo_out = 1; c.Gra = 1; c.Rin = 1; end
                end else if (op == OP_BR) begin
                    if (t == 3) begin c.Gra = 1; c.Rout = 1; end
                    if (t == 4) begin c.PCout = 1; c.RYin = 1; end
                    if (t == 5) begin c.Cout = 1; c.RZin = 1; end
                    if (t == 6) begin c.Zlo_out = tk; c.PCin = tk; end
                end else if (t == 3) begin
                    case (op)
                        OP_JR:   begin c.Gra = 1; c.Rout = 1; c.PCin = 1; end
                        OP_IN:   begin c.Inport_out = 1; c.Gra = 1; c.Rin = 1; end
                        OP_OUT:  begin c.Gra = 1; c.Rout = 1; c.Outport_in = 1; end
                        OP_MFHI: begin c.HIout = 1; c.Gra = 1; c.Rin = 1; end
                        OP_MFLO: begin c.LOout = 1; c.Gra = 1; c.Rin = 1; end
                        default: ;
                    endcase
                end
            end
        endcase
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drainCycle(input logic conBit, input logic stopBit);
        sbItem_t item;
        bus.con_ff_bit = conBit;
        bus.stop       = stopBit;
        @(negedge clock);
        item = sb.pop_front();
        checkOutput(item.tag, {bus.run, observe()}, item.word);
        @(posedge clock);
        #1;
    endtask

    // Entered at posedge+1 with the DUT in T0; launches op and checks every cycle.
    task automatic applyStimulus(input string name, input logic [31:0] ir, input logic conT3,
                                 input logic conT6, input int stopAt, input int maxCycles,
                                 input int haltedAfter);
        int n;
        int total;
        n = instrLen(ir[31:27]);
        if (maxCycles < n) n = maxCycles;
        bus.IR = ir;
        for (int t = 0; t < n; t++)
            sb.push_back('{$sformatf("%s.T%0d", name, t), {1'b1, stepWord(ir[31:27], t, conT3)}});
        for (int h = 0; h < haltedAfter; h++)
            sb.push_back('{$sformatf("%s.halted%0d", name, h), 32'h0});
        total = n + haltedAfter;
        for (int i = 0; i < total; i++)
            drainCycle((i == 3) ? conT3 : ((i == 6) ? conT6 : 1'b0), (i == stopAt));
        bus.stop       = 1'b0;
        bus.con_ff_bit = 1'b0;
    endtask

    task automatic resetDut(input string name);
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{$sformatf("%s.clear%0d", name, i), 32'h0});
            drainCycle(1'b0, 1'b0);
        end
        clear = 1'b0;
    endtask

    function automatic logic [31:0] mkIr(input logic [4:0] op);
        logic [26:0] low;
        low = 27'($urandom);
        return {op, low};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [4:0] plainOps[$];
        checks         = 0;
        failures       = 0;
        clear          = 1'b1;
        bus.IR         = 32'h0;
        bus.con_ff_bit = 1'b0;
        bus.stop       = 1'b0;

        resetDut("init");
        applyStimulus("add", 32'h18000000, 1'b0, 1'b0, -1, 99, 0);
        applyStimulus("nop", mkIr(OP_NOP), 1'b0, 1'b0, -1, 99, 0);
        applyStimulus("undef", mkIr(5'b10101), 1'b0, 1'b0, -1, 99, 0);

        plainOps = '{OP_SUB, OP_ROR, OP_ADDI, OP_ORI, OP_LDI, OP_LD, OP_ST, OP_MUL,
                     OP_DIV, OP_NEG, OP_NOT, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
        foreach (plainOps[k])
            applyStimulus($sformatf("op%02h", plainOps[k]), mkIr(plainOps[k]), 1'b0, 1'b0, -1, 99, 0);

        applyStimulus("brTaken", mkIr(OP_BR), 1'b1, 1'b0, -1, 99, 0);
        applyStimulus("brNot", mkIr(OP_BR), 1'b0, 1'b1, -1, 99, 0);

        applyStimulus("ldCut", mkIr(OP_LD), 1'b0, 1'b0, -1, 5, 0);
        resetDut("midLd");
        applyStimulus("postRst", 32'h18000000, 1'b0, 1'b0, -1, 99, 0);

        applyStimulus("stopAdd", 32'h18000000, 1'b0, 1'b0, 4, 99, 3);
        resetDut("afterStop");

        applyStimulus("halt", mkIr(OP_HALT), 1'b0, 1'b0, -1, 99, 20);
        resetDut("afterHalt");
        applyStimulus("resume", mkIr(OP_MFLO), 1'b0, 1'b0, -1, 99, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
